// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Brief    : Shared sizing constants for the integer register file.
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int          c_reg_num      = 32;     // architectural registers
  localparam int          c_addr_w       = 5;      // log2(c_reg_num)
  localparam int          c_data_w       = 32;     // register width
  localparam logic [31:0] c_zero_word    = 32'h0;
  localparam logic [4:0]  c_nop_reg_addr = 5'd0;   // x0, hardwired to zero
  localparam logic        c_rst_enable   = 1'b1;
  localparam logic        c_write_enable = 1'b1;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Brief    : Per-register busy bits (set at issue, cleared at write-back,
//             wiped by flush) and the two read-port stall lookups.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int REG_NUM = c_reg_num,
  parameter int ADDR_W  = c_addr_w
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  input  logic              flush,
  output logic              rbusy1,
  output logic              rbusy2
);

  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  // Next busy vector: flush beats everything, a new issue beats a completing write.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (busy_set && (busy_addr == ADDR_W'(r))) begin
          busy_d[r] = 1'b1;
        end else if (we && (waddr == ADDR_W'(r))) begin
          busy_d[r] = 1'b0;
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register, cleared the moment reset is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A write completing this cycle is bypassed to the reader, so it never stalls.
  assign rbusy1 = !rst && re1 && (raddr1 != '0) && busy_q[raddr1]
                  && !(we && (waddr == raddr1));
  assign rbusy2 = !rst && re2 && (raddr2 != '0) && busy_q[raddr2]
                  && !(we && (waddr == raddr2));

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module   : regfile
//  Brief    : Integer register file with WB->ID write bypass on both read
//             ports and a busy scoreboard for load-use stall detection.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile
  import regfile_pkg::*;
#(
  parameter int REG_NUM = c_reg_num,
  parameter int ADDR_W  = c_addr_w,
  parameter int DATA_W  = c_data_w
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rbusy1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              rbusy2,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  input  logic              flush
);

  logic [DATA_W-1:0] regs_q [REG_NUM];

  // Register storage; writes to x0 are dropped so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Read port 1: reset/x0/disabled give zero, a same-cycle write is forwarded.
  always_comb begin
    rdata1 = '0;
    if (rst || (raddr1 == '0) || !re1) begin
      rdata1 = '0;
    end else if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs_q[raddr1];
    end
  end

  // Read port 2: same selection rules as port 1.
  always_comb begin
    rdata2 = '0;
    if (rst || (raddr2 == '0) || !re2) begin
      rdata2 = '0;
    end else if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs_q[raddr2];
    end
  end

  regfile_scoreboard #(
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .re1       (re1),
    .raddr1    (raddr1),
    .re2       (re2),
    .raddr2    (raddr2),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .flush     (flush),
    .rbusy1    (rbusy1),
    .rbusy2    (rbusy2)
  );

endmodule : regfile
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile
//  Brief    : Self-checking bench for regfile: directed scenarios followed by
//             random traffic compared against an array-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        rbusy1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        rbusy2;
  logic        busy_set;
  logic [4:0]  busy_addr;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  regfile dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .rbusy1    (rbusy1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .rbusy2    (rbusy2),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .flush     (flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
    if (rst || ra == 5'd0 || !re) return 32'h0;
    if (we && waddr == ra)        return wdata;
    return m_regs[ra];
  endfunction

  function automatic logic [31:0] exp_busy(input logic re, input logic [4:0] ra);
    if (rst || !re || ra == 5'd0)  return 32'h0;
    if (we && waddr == ra)         return 32'h0;
    return {31'h0, m_busy[ra]};
  endfunction

  // Apply one clock edge to the model, using the inputs present at the edge.
  task automatic model_edge();
    if (rst) begin
      model_clear();
    end else begin
      if (we && waddr != 5'd0) m_regs[waddr] = wdata;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
        if (we) m_busy[waddr] = 1'b0;
        if (busy_set && busy_addr != 5'd0) m_busy[busy_addr] = 1'b1;
      end
    end
  endtask

  // Check all outputs against the model, then advance one cycle.
  task automatic cyc();
    #1;
    check("rdata1", rdata1, exp_rd(re1, raddr1));
    check("rdata2", rdata2, exp_rd(re2, raddr2));
    check("rbusy1", {31'h0, rbusy1}, exp_busy(re1, raddr1));
    check("rbusy2", {31'h0, rbusy2}, exp_busy(re2, raddr2));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    busy_set = 0; busy_addr = 0; flush = 0;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    model_clear();
    idle();
    rst = 1'b1;

    // 1: write attempted under reset is discarded, reads give zero
    we = 1; waddr = 3; wdata = 32'd5; re1 = 1; raddr1 = 3;
    @(negedge clk);
    #1 check("t1_rd_in_rst", rdata1, 32'h0);
    cyc();
    cyc();
    rst = 1'b0;
    we = 0;
    #1 check("t1_reg3_after_rst", rdata1, 32'h0);
    cyc();

    // 2: write to x0 dropped
    idle(); we = 1; waddr = 0; wdata = 32'hFFFF_FFFF;
    cyc();
    idle(); re1 = 1; raddr1 = 0;
    #1 check("t2_x0", rdata1, 32'h0);
    cyc();

    // 3: bypass on both ports, then stored value
    idle(); we = 1; waddr = 7; wdata = 32'hDEAD_BEEF;
    re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 7;
    #1 check("t3_byp1", rdata1, 32'hDEAD_BEEF);
    check("t3_byp2", rdata2, 32'hDEAD_BEEF);
    cyc();
    we = 0;
    #1 check("t3_st1", rdata1, 32'hDEAD_BEEF);
    check("t3_st2", rdata2, 32'hDEAD_BEEF);
    cyc();

    // 4: busy set, then write-back clears it with bypass
    idle(); busy_set = 1; busy_addr = 9;
    cyc();
    idle(); re2 = 1; raddr2 = 9;
    #1 check("t4_busy", {31'h0, rbusy2}, 32'h1);
    cyc();
    we = 1; waddr = 9; wdata = 32'd42;
    #1 check("t4_wb_nobusy", {31'h0, rbusy2}, 32'h0);
    check("t4_wb_byp", rdata2, 32'd42);
    cyc();
    we = 0;
    #1 check("t4_cleared", {31'h0, rbusy2}, 32'h0);
    cyc();

    // 5: set wins over clear on the same edge; flush wipes and ignores set
    idle(); busy_set = 1; busy_addr = 9;
    cyc();
    we = 1; waddr = 9; wdata = 32'd1;
    cyc();
    idle(); re2 = 1; raddr2 = 9;
    #1 check("t5_set_wins", {31'h0, rbusy2}, 32'h1);
    cyc();
    idle(); flush = 1; busy_set = 1; busy_addr = 4;
    cyc();
    idle(); re1 = 1; raddr1 = 4; re2 = 1; raddr2 = 9;
    #1 check("t5_flush4", {31'h0, rbusy1}, 32'h0);
    check("t5_flush9", {31'h0, rbusy2}, 32'h0);
    cyc();

    // 6: disabled port reads zero and never stalls
    idle(); busy_set = 1; busy_addr = 7;
    cyc();
    idle(); re1 = 0; raddr1 = 7; re2 = 1; raddr2 = 7;
    #1 check("t6_rd_dis", rdata1, 32'h0);
    check("t6_busy_dis", {31'h0, rbusy1}, 32'h0);
    check("t6_busy_en", {31'h0, rbusy2}, 32'h1);
    cyc();

    // Random traffic, including occasional mid-operation reset
    for (int n = 0; n < 600; n++) begin
      idle();
      we        = ($urandom_range(0, 2) != 0);
      waddr     = rnd_addr();
      wdata     = $urandom();
      re1       = ($urandom_range(0, 3) != 0);
      raddr1    = rnd_addr();
      re2       = ($urandom_range(0, 3) != 0);
      raddr2    = rnd_addr();
      busy_set  = ($urandom_range(0, 2) == 0);
      busy_addr = rnd_addr();
      flush     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        model_clear();
        cyc();
        rst = 1'b0;
      end else begin
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile
`default_nettype wire
